calc_display: RTL and testbench



---
 rtl/calc_display.sv | 189 ++++++++++++++++++
 tb/tb_calc_display.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/calc_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : calc_display
//  Purpose  : Reassembles the core's digit-serial result stream into an
//             8-digit frame and scans it onto multiplexed active-low 7-seg
//             displays, with leading-zero blanking and a latched error banner.
//  Revision : 1.0  initial release
// ============================================================================
module calc_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       frame_valid
);

    localparam logic [1:0] STATUS_ERROR = 2'b00;
    localparam logic [1:0] STATUS_READY = 2'b10;
    localparam int         PRESC_W      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_R     = 8'hAF;
    localparam logic [7:0] SEG_O     = 8'hA3;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [2:0]          expect_idx;
    logic [2:0]          expect_next;
    logic                shadow_we;
    logic                commit;
    logic [7:0][3:0]     shadow;
    logic [7:0][3:0]     frame;
    logic [7:0][3:0]     commit_frame;
    logic                err;
    logic [PRESC_W-1:0]  prescaler;
    logic [2:0]          scan;
    logic                scan_tick;
    logic [7:0]          nonzero;
    logic                lead_blank;
    logic [7:0]          digit_seg;

    function automatic logic [7:0] bcd_seg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Capture FSM: any out-of-order position or a return to ready abandons the sweep.
    always_comb begin
        state_next  = state;
        expect_next = expect_idx;
        shadow_we   = 1'b0;
        commit      = 1'b0;
        case (state)
            IDLE: begin
                if (status != STATUS_READY && pos == 4'd0) begin
                    shadow_we   = 1'b1;
                    expect_next = 3'd1;
                    state_next  = CAPTURE;
                end
            end
            CAPTURE: begin
                if (status == STATUS_READY) begin
                    state_next  = IDLE;
                    expect_next = 3'd0;
                end else if (pos == {1'b0, expect_idx}) begin
                    shadow_we = 1'b1;
                    if (expect_idx == 3'd7) begin
                        commit      = 1'b1;
                        state_next  = IDLE;
                        expect_next = 3'd0;
                    end else begin
                        expect_next = expect_idx + 3'd1;
                    end
                end else begin
                    state_next  = IDLE;
                    expect_next = 3'd0;
                end
            end
            default: begin
                state_next  = IDLE;
                expect_next = 3'd0;
            end
        endcase
    end

    always_comb begin
        commit_frame    = shadow;
        commit_frame[7] = data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            expect_idx  <= 3'd0;
            shadow      <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_next;
            expect_idx  <= expect_next;
            frame_valid <= commit;
            if (shadow_we) begin
                shadow[pos[2:0]] <= data;
            end
            if (commit) begin
                frame <= commit_frame;
            end
            if (status == STATUS_ERROR) begin
                err <= 1'b1;
            end
        end
    end

    assign scan_tick = (prescaler == PRESC_W'(REFRESH_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler <= '0;
            scan      <= 3'd0;
        end else if (scan_tick) begin
            prescaler <= '0;
            scan      <= scan + 3'd1;
        end else begin
            prescaler <= prescaler + PRESC_W'(1);
        end
    end

    // A digit is blanked when it and every more-significant digit are zero.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            nonzero[i] = (frame[i] != 4'd0);
        end
        lead_blank = (scan != 3'd0) && ((nonzero >> scan) == 8'd0);
    end

    always_comb begin
        digit_seg = SEG_BLANK;
        if (err) begin
            case (scan)
                3'd0:       digit_seg = SEG_O;
                3'd1, 3'd2: digit_seg = SEG_R;
                3'd3:       digit_seg = SEG_E;
                default:    digit_seg = SEG_BLANK;
            endcase
        end else if (lead_blank) begin
            digit_seg = SEG_BLANK;
        end else begin
            digit_seg = bcd_seg(frame[scan]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            an  <= 8'hFE;
            seg <= 8'hC0;
        end else begin
            an  <= ~(8'h01 << scan);
            seg <= digit_seg;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_calc_display
//  Purpose  : Randomised self-checking bench for calc_display against a
//             queue-based behavioural model of frame capture and display.
//  Revision : 1.0  initial release
// ============================================================================
module tb_calc_display;

    localparam int DIV = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an;
    logic [7:0] seg;
    logic       frame_valid;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int         cnt;
    bit         merr;
    logic [3:0] mframe [8];
    int         sweep_q [$];
    int         fv_seen;

    calc_display #(.REFRESH_DIV(DIV)) dut (
        .clock       (clock),
        .reset       (reset),
        .status      (status),
        .data        (data),
        .pos         (pos),
        .an          (an),
        .seg         (seg),
        .frame_valid (frame_valid)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] enc(input logic [3:0] v);
        logic [7:0] tbl [10];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        if (v > 4'd9) return 8'hFF;
        return tbl[v];
    endfunction

    function automatic logic [7:0] model_seg(input int s);
        bit all_zero;
        if (merr) begin
            case (s)
                0:       return 8'hA3;
                1, 2:    return 8'hAF;
                3:       return 8'h86;
                default: return 8'hFF;
            endcase
        end
        all_zero = 1'b1;
        for (int j = s; j < 8; j++) begin
            if (mframe[j] != 4'd0) all_zero = 1'b0;
        end
        if (s > 0 && all_zero) return 8'hFF;
        return enc(mframe[s]);
    endfunction

    task automatic step(input bit rst, input logic [1:0] st, input logic [3:0] d, input logic [3:0] p);
        logic [7:0] want_an;
        logic [7:0] want_seg;
        logic [7:0] one;
        logic       want_fv;
        int         s;
        @(negedge clock);
        reset  = rst;
        status = st;
        data   = d;
        pos    = p;
        one     = 8'h01;
        want_fv = 1'b0;
        if (rst) begin
            want_an  = 8'hFE;
            want_seg = 8'hC0;
            merr     = 1'b0;
            cnt      = 0;
            sweep_q.delete();
            for (int i = 0; i < 8; i++) mframe[i] = 4'd0;
        end else begin
            s        = (cnt / DIV) % 8;
            want_an  = ~(one << s);
            want_seg = model_seg(s);
            cnt++;
            if (sweep_q.size() == 0) begin
                if (st != 2'b10 && p == 4'd0) sweep_q.push_back(int'(d));
            end else if (st == 2'b10 || int'(p) != sweep_q.size()) begin
                sweep_q.delete();
            end else begin
                sweep_q.push_back(int'(d));
                if (sweep_q.size() == 8) begin
                    for (int i = 0; i < 8; i++) mframe[i] = 4'(sweep_q[i]);
                    want_fv = 1'b1;
                    sweep_q.delete();
                end
            end
            if (st == 2'b00) merr = 1'b1;
        end
        @(posedge clock);
        #1;
        if (frame_valid === 1'b1) fv_seen++;
        check_eq("an", an, want_an);
        check_eq("seg", seg, want_seg);
        check_eq("frame_valid", {7'd0, frame_valid}, {7'd0, want_fv});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b10, 4'(i), 4'd0);
    endtask

    task automatic rand_sweep();
        int         hi;
        logic [1:0] st;
        logic [3:0] d;
        logic [3:0] p;
        hi = $urandom_range(0, 8);
        for (int k = 0; k < 8; k++) begin
            st = ($urandom_range(0, 19) == 0) ? 2'b10 : 2'b01;
            p  = ($urandom_range(0, 14) == 0) ? 4'($urandom_range(0, 15)) : 4'(k);
            d  = (k >= hi) ? 4'd0 : 4'($urandom_range(0, 15));
            step(1'b0, st, d, p);
        end
        idle($urandom_range(0, 12));
    endtask

    initial begin
        int fv_before;
        logic [3:0] full_data [8];
        reset   = 1'b1;
        status  = 2'b10;
        data    = 4'd0;
        pos     = 4'd0;
        fv_seen = 0;

        step(1'b1, 2'b10, 4'd0, 4'd0);
        step(1'b1, 2'b10, 4'd0, 4'd0);
        idle(3);

        // Full sweep showing 1234
        full_data = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        fv_before = fv_seen;
        for (int k = 0; k < 8; k++) step(1'b0, 2'b01, full_data[k], 4'(k));
        idle(40);
        check_eq("sweep_pulses", 8'(fv_seen - fv_before), 8'd1);

        // Abort by ready status arriving together with pos=3
        fv_before = fv_seen;
        for (int k = 0; k < 3; k++) step(1'b0, 2'b01, 4'd9, 4'(k));
        step(1'b0, 2'b10, 4'd9, 4'd3);
        idle(40);
        check_eq("abort_pulses", 8'(fv_seen - fv_before), 8'd0);

        // Skipped position, then a clean all-zero sweep
        step(1'b0, 2'b01, 4'd5, 4'd0);
        step(1'b0, 2'b01, 4'd5, 4'd1);
        step(1'b0, 2'b01, 4'd5, 4'd3);
        for (int k = 0; k < 8; k++) step(1'b0, 2'b01, 4'd0, 4'(k));
        idle(40);

        for (int n = 0; n < 60; n++) rand_sweep();

        // Error banner persists through ready and further sweeps
        step(1'b0, 2'b00, 4'd0, 4'd5);
        idle(40);
        rand_sweep();
        idle(40);

        step(1'b1, 2'b10, 4'd0, 4'd0);
        step(1'b1, 2'b10, 4'd0, 4'd0);
        for (int n = 0; n < 30; n++) rand_sweep();
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
